// File: rtl/karatsuba2_clmul_ds.sv
// Two-way Karatsuba carry-less (GF(2)[x]) multiplier, digit-serial, no reduction.
// Three LO-bit sub-products accumulate DIGIT bits of the A side per cycle, then combine once.
module karatsuba2_clmul_ds #(
  parameter int WIDTH = 571,
  parameter int DIGIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   c
);

  localparam int LO   = (WIDTH + 1) / 2;
  localparam int PW   = 2 * LO - 1;
  localparam int NDIG = (LO + DIGIT - 1) / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int EW   = 4 * LO;

  if (WIDTH < 2) begin : g_bad_width
    $error("karatsuba2_clmul_ds: WIDTH must be >= 2");
  end
  if (DIGIT < 1 || DIGIT > LO) begin : g_bad_digit
    $error("karatsuba2_clmul_ds: DIGIT must be in 1..LO");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    COMB = 2'd2
  } state_t;

  state_t          state_r;
  logic [KW-1:0]   k_r;
  logic [LO-1:0]   a_lo_r, a_hi_r, a_m_r;
  logic [PW-1:0]   b_lo_r, b_hi_r, b_m_r;
  logic [PW-1:0]   p_ll_r, p_hh_r, p_m_r;

  logic [LO-1:0]   a_lo_s, a_hi_s, b_lo_s, b_hi_s;
  logic [PW-1:0]   mid_s;
  logic [EW-1:0]   wide_s;

  // Accumulate one digit of the A side against the pre-shifted B side
  function automatic logic [PW-1:0] mac_digit(input logic [PW-1:0] acc,
                                              input logic [DIGIT-1:0] dig,
                                              input logic [PW-1:0] bs);
    logic [PW-1:0] r;
    r = acc;
    for (int i = 0; i < DIGIT; i++) begin
      if (dig[i]) begin
        r = r ^ (bs << i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Operand split; the high half is zero-padded to LO bits for odd widths
  always_comb begin
    a_lo_s = a[LO-1:0];
    a_hi_s = LO'(a >> LO);
    b_lo_s = b[LO-1:0];
    b_hi_s = LO'(b >> LO);
  end

  // Karatsuba recombination of the three sub-products
  always_comb begin
    mid_s  = p_m_r ^ p_ll_r ^ p_hh_r;
    wide_s = ({{(EW-PW){1'b0}}, p_hh_r} << (2 * LO))
           ^ ({{(EW-PW){1'b0}}, mid_s} << LO)
           ^  {{(EW-PW){1'b0}}, p_ll_r};
  end

  // Control FSM, digit-serial datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      k_r     <= '0;
      a_lo_r  <= '0;
      a_hi_r  <= '0;
      a_m_r   <= '0;
      b_lo_r  <= '0;
      b_hi_r  <= '0;
      b_m_r   <= '0;
      p_ll_r  <= '0;
      p_hh_r  <= '0;
      p_m_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      c       <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_lo_r  <= a_lo_s;
            a_hi_r  <= a_hi_s;
            a_m_r   <= a_lo_s ^ a_hi_s;
            b_lo_r  <= PW'(b_lo_s);
            b_hi_r  <= PW'(b_hi_s);
            b_m_r   <= PW'(b_lo_s ^ b_hi_s);
            p_ll_r  <= '0;
            p_hh_r  <= '0;
            p_m_r   <= '0;
            k_r     <= '0;
            busy    <= 1'b1;
            state_r <= MUL;
          end else begin
            busy <= 1'b0;
          end
        end
        MUL: begin
          // A halves shift down so the current digit always sits at bit 0
          p_ll_r <= mac_digit(p_ll_r, a_lo_r[DIGIT-1:0], b_lo_r);
          p_hh_r <= mac_digit(p_hh_r, a_hi_r[DIGIT-1:0], b_hi_r);
          p_m_r  <= mac_digit(p_m_r,  a_m_r[DIGIT-1:0],  b_m_r);
          a_lo_r <= a_lo_r >> DIGIT;
          a_hi_r <= a_hi_r >> DIGIT;
          a_m_r  <= a_m_r  >> DIGIT;
          b_lo_r <= b_lo_r << DIGIT;
          b_hi_r <= b_hi_r << DIGIT;
          b_m_r  <= b_m_r  << DIGIT;
          done   <= 1'b0;
          if (k_r == KW'(NDIG - 1)) begin
            state_r <= COMB;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        COMB: begin
          c       <= wide_s[2*WIDTH-1:0];
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba2_clmul_ds.sv
// Scoreboard bench: several parameter sets on random/directed vectors against a
// schoolbook clmul model, plus a handshake and reset instance at default size.
module tb_karatsuba2_clmul_ds;

  logic clk;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   n_fin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cfg_w(input int i);
    case (i)
      0: return 8;
      1: return 9;
      2: return 571;
      3: return 571;
      default: return 571;
    endcase
  endfunction

  function automatic int cfg_d(input int i);
    case (i)
      0: return 3;
      1: return 2;
      2: return 286;
      3: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_n(input int i);
    case (i)
      0: return 60;
      1: return 200;
      2: return 40;
      3: return 12;
      default: return 1000;
    endcase
  endfunction

  // Schoolbook carry-less product over arbitrary-width operands
  function automatic logic [1151:0] clmul(input logic [575:0] x, input logic [575:0] y);
    logic [1151:0] r;
    r = '0;
    for (int i = 0; i < 576; i++)
      if (x[i]) r = r ^ ({576'd0, y} << i);
    return r;
  endfunction

  function automatic logic [575:0] rand576();
    logic [575:0] v;
    for (int j = 0; j < 18; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // Directed operands first (small, all-ones, MSB-only, zero, single-bit), then random
  function automatic logic [575:0] pat(input int i, input int w, input bit second);
    logic [575:0] v;
    case (i)
      0: v = 576'd3;
      1: v = {576{1'b1}};
      2: v = 576'd1 << (w - 1);
      3: v = second ? 576'hA5 : 576'd0;
      4: v = 576'd1 << $urandom_range(w - 1, 0);
      default: v = rand576();
    endcase
    for (int j = w; j < 576; j++) v[j] = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [1151:0] got, input logic [1151:0] exp);
    int fd;
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      fd = -1;
      for (int i = 1151; i >= 0; i--) if (got[i] !== exp[i]) fd = i;
      $display("FAIL %s: got[127:0]=%h expected[127:0]=%h first differing bit %0d",
               nm, got[127:0], exp[127:0], fd);
    end
  endtask

  // ---------------- parameter sweep instances ----------------
  for (genvar g = 0; g < 5; g++) begin : g_cfg
    localparam int W    = cfg_w(g);
    localparam int D    = cfg_d(g);
    localparam int NV   = cfg_n(g);
    localparam int NDIG = ((W + 1) / 2 + D - 1) / D;

    logic           rst_g, start_g, busy_g, done_g;
    logic [W-1:0]   a_g, b_g;
    logic [2*W-1:0] c_g;
    logic [1151:0]  exp_q[$];
    int             t_q[$];
    logic [1151:0]  mon_e;
    int             mon_t;

    karatsuba2_clmul_ds #(.WIDTH(W), .DIGIT(D)) dut (
      .clk(clk), .rst(rst_g), .start(start_g), .a(a_g), .b(b_g),
      .busy(busy_g), .done(done_g), .c(c_g)
    );

    task automatic issue(input logic [575:0] x, input logic [575:0] y);
      a_g     = W'(x);
      b_g     = W'(y);
      start_g = 1'b1;
      exp_q.push_back(clmul(x, y));
      t_q.push_back(cyc + NDIG + 2);
      @(negedge clk);
      start_g = 1'b0;
      a_g     = W'(rand576());
      b_g     = W'(rand576());
      chk($sformatf("cfg%0d busy_after_start", g), 1152'(busy_g), 1152'(1));
    endtask

    task automatic wait_done();
      int n;
      n = 0;
      while (!done_g && n < NDIG + 8) begin
        @(negedge clk);
        n++;
      end
      if (!done_g) chk($sformatf("cfg%0d done_timeout", g), 1152'(0), 1152'(1));
    endtask

    always @(negedge clk) begin
      if (done_g) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("cfg%0d unexpected_done", g), 1152'(1), 1152'(0));
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = t_q.pop_front();
          chk($sformatf("cfg%0d W=%0d D=%0d product", g, W, D), 1152'(c_g), mon_e);
          chk($sformatf("cfg%0d done_cycle", g), 1152'(cyc), 1152'(mon_t));
          chk($sformatf("cfg%0d busy_low_at_done", g), 1152'(busy_g), 1152'(0));
        end
      end
    end

    initial begin
      rst_g = 1'b1; start_g = 1'b0; a_g = '0; b_g = '0;
      repeat (3) @(negedge clk);
      chk($sformatf("cfg%0d reset_busy", g), 1152'(busy_g), 1152'(0));
      chk($sformatf("cfg%0d reset_c", g), 1152'(c_g), 1152'(0));
      rst_g = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NV + 5; i++) begin
        issue(pat(i, W, 1'b0), pat(i, W, 1'b1));
        wait_done();
      end
      repeat (NDIG + 6) @(negedge clk);
      chk($sformatf("cfg%0d scoreboard_empty", g), 1152'(exp_q.size()), 1152'(0));
      n_fin++;
    end
  end

  // ---------------- handshake / reset instance (defaults) ----------------
  localparam int HW    = 571;
  localparam int HNDIG = 36;

  logic            rst_h, start_h, busy_h, done_h;
  logic [HW-1:0]   a_h, b_h;
  logic [2*HW-1:0] c_h;
  logic [1151:0]   hq[$];
  int              ht[$];
  logic [1151:0]   h_e;
  int              h_t;

  karatsuba2_clmul_ds dut_h (
    .clk(clk), .rst(rst_h), .start(start_h), .a(a_h), .b(b_h),
    .busy(busy_h), .done(done_h), .c(c_h)
  );

  task automatic issue_h(input logic [575:0] x, input logic [575:0] y);
    a_h     = HW'(x);
    b_h     = HW'(y);
    start_h = 1'b1;
    hq.push_back(clmul(x, y));
    ht.push_back(cyc + HNDIG + 2);
    @(negedge clk);
    start_h = 1'b0;
    chk("hs busy_after_start", 1152'(busy_h), 1152'(1));
  endtask

  task automatic wait_done_h();
    int n;
    n = 0;
    while (!done_h && n < HNDIG + 8) begin
      @(negedge clk);
      n++;
    end
    if (!done_h) chk("hs done_timeout", 1152'(0), 1152'(1));
  endtask

  always @(negedge clk) begin
    if (done_h) begin
      if (hq.size() == 0) begin
        chk("hs unexpected_done", 1152'(1), 1152'(0));
      end else begin
        h_e = hq.pop_front();
        h_t = ht.pop_front();
        chk("hs product", 1152'(c_h), h_e);
        chk("hs done_cycle", 1152'(cyc), 1152'(h_t));
      end
    end
  end

  initial begin
    logic [575:0] x, y;
    rst_h = 1'b1; start_h = 1'b0; a_h = '0; b_h = '0;
    repeat (3) @(negedge clk);
    chk("hs reset_done", 1152'(done_h), 1152'(0));
    rst_h = 1'b0;
    @(negedge clk);

    // start mid-operation with new operands is ignored; late operand changes too
    x = pat(5, HW, 1'b0); y = pat(5, HW, 1'b1);
    issue_h(x, y);
    repeat (4) @(negedge clk);
    a_h = HW'(rand576()); b_h = HW'(rand576()); start_h = 1'b1;
    @(negedge clk);
    start_h = 1'b0;
    wait_done_h();

    // back-to-back: start in the done cycle; busy drops for that cycle only
    issue_h(pat(6, HW, 1'b0), pat(6, HW, 1'b1));
    wait_done_h();
    chk("hs busy_low_in_done_cycle", 1152'(busy_h), 1152'(0));
    issue_h(pat(1, HW, 1'b0), pat(2, HW, 1'b1));
    wait_done_h();
    @(negedge clk);

    // reset at MUL cycle 10 aborts with no done and clears c
    issue_h(pat(7, HW, 1'b0), pat(7, HW, 1'b1));
    repeat (9) @(negedge clk);
    rst_h = 1'b1;
    @(negedge clk);
    hq.delete();
    ht.delete();
    rst_h = 1'b0;
    chk("hs abort_busy", 1152'(busy_h), 1152'(0));
    chk("hs abort_c", 1152'(c_h), 1152'(0));
    repeat (HNDIG + 6) @(negedge clk);
    chk("hs abort_c_held", 1152'(c_h), 1152'(0));

    // reset wins over a simultaneous start
    a_h = HW'(rand576()); b_h = HW'(rand576());
    rst_h = 1'b1; start_h = 1'b1;
    @(negedge clk);
    rst_h = 1'b0; start_h = 1'b0;
    chk("hs reset_beats_start", 1152'(busy_h), 1152'(0));

    issue_h(pat(8, HW, 1'b0), pat(8, HW, 1'b1));
    wait_done_h();
    repeat (HNDIG + 6) @(negedge clk);
    chk("hs scoreboard_empty", 1152'(hq.size()), 1152'(0));
    n_fin++;
  end

  // ---------------- completion ----------------
  initial begin
    n_tests = 0; n_fail = 0; n_fin = 0; cyc = 0;
    while (n_fin < 6 && cyc < 90000) @(negedge clk);
    if (n_fin < 6) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_timeout: finished %0d of 6 streams", n_fin);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
